icache_set_assoc: RTL and testbench
===================================

Name: icache_set_assoc

Overview:
- Parametrised set-associative instruction cache between the instruction fetch unit and the memory controller.
- Multi-word lines, N ways per set, and round-robin replacement with invalid-way preference.
- Fetch addresses are halfword-aligned, so 32-bit instructions may straddle two words or two lines. The cache returns the full 32-bit window starting at the fetch address.
- Misses are serviced by an internal refill FSM that fetches one word per memory handshake. A rob_clear squashes pending output without corrupting the arrays.

Parameters:
- SET_BIT, 4: log2 of number of sets.
- WAY_NUM, 2: ways per set; legal values 1, 2, 4.
- LINE_WORD_BIT, 2: log2 of 32-bit words per line (default 4 words, 16 B).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; all state frozen when low
- inst_valid  input  1  fetch request; held with inst_addr until inst_ready or rob_clear
- inst_addr  input  32  fetch address, bit0 = 0
- inst_ready  output  1  registered: inst_res valid for the current inst_addr
- inst_res  output  32  {mem[a+3..a]} little-endian window at inst_addr
- mem_valid  output  1  refill word request
- mem_addr  output  32  word-aligned refill address
- mem_result  input  32  returned word, valid with mem_ready
- mem_ready  input  1  one-cycle completion pulse for mem_addr
- rob_clear  input  1  flush pending fetch output
- hit_cnt  output  32  count of hit responses (inst_ready cycles)
- miss_cnt  output  32  count of line refills started

Behaviour:
- Address split:
  - off = addr[LINE_WORD_BIT+1:2]
  - idx = addr[SET_BIT+LINE_WORD_BIT+1 : LINE_WORD_BIT+2]
  - tag = remaining upper bits
- Window a needs word A = a>>2 and, if a[1] = 1, word A+1. Word A+1 may lie in the next line, and so in the next set.
- Reset: all valid bits 0, victim pointers 0, FSM IDLE, inst_ready 0, inst_res 0, mem_valid 0, mem_addr 0, counters 0. Tag and data contents are don't-care.
- Priority each cycle: rst_in > rob_clear > !rdy_in (hold everything) > normal.
- The memory controller shares rdy_in and never pulses mem_ready while rdy_in is low.
- FSM state IDLE:
  - inst_valid && every needed line hits: next cycle inst_ready = 1 and inst_res = assembled window; hit_cnt += 1.
  - Otherwise inst_ready <= 0. On any miss: choose the first missing line (line of A before line of A+1), latch its line address and set, then go to REFILL.
  - Victim = lowest-numbered invalid way, else victim_ptr[set].
  - miss_cnt += 1.
- FSM state REFILL:
  - mem_valid = 1; mem_addr = line base + 4*word_cnt.
  - Each mem_ready writes mem_result into data[set][victim][word_cnt] and increments word_cnt.
  - After the last word (word_cnt = 2^LINE_WORD_BIT - 1):
    - set valid and tag for the victim;
    - victim_ptr[set] = (victim_ptr[set] + 1) mod WAY_NUM, advanced only when all ways were valid;
    - mem_valid <= 0;
    - return to IDLE.
  - The request is re-evaluated in IDLE; a straddling miss therefore refills a second line.
  - mem_valid deasserts for at least one cycle between lines.
  - inst_ready stays 0 throughout REFILL.
- mem handshake: mem_addr is stable while mem_valid = 1 until mem_ready. mem_ready while in IDLE is ignored.
- rob_clear:
  - inst_ready <= 0 and inst_res <= 0 next cycle.
  - A REFILL in progress continues to completion and installs the line; it cannot be aborted at the memory side.
  - No response is produced for the squashed request; the next request is served fresh.
- A line is never valid with partial data: the valid bit is set only on the last word.
- Counters wrap modulo 2^32.
- WAY_NUM = 1 degenerates to direct-mapped; the victim pointer is unused.

Test Plan:
- Cold miss, aligned:
  - Stimulus: fetch 0x0000_1000; memory words 0x1000..0x100C = 0x11111111, 0x22222222, 0x33333333, 0x44444444, mem_ready 2 cycles after each mem_valid.
  - Required: exactly 4 mem requests, in order 0x1000, 0x1004, 0x1008, 0x100C.
  - Required: then inst_ready = 1 with inst_res = 0x11111111; miss_cnt = 1, hit_cnt = 1.
- Halfword window inside a line:
  - Stimulus: after the above, fetch 0x1002.
  - Required: inst_ready on the next cycle, inst_res = 0x22221111; no mem_valid.
- Line-straddling fetch:
  - Stimulus: fetch 0x100E with line 0x1010 absent.
  - Required: refill of 0x1010..0x101C, then inst_res = {low half of word 0x1010, 0x4444}; miss_cnt increments by 1.
- Associativity and replacement (WAY_NUM = 2, SET_BIT = 4, LINE_WORD_BIT = 2):
  - Stimulus: fill 0x1000, 0x2000, 0x3000 (same set 0), then re-fetch 0x1000.
  - Required: 0x3000 evicts the 0x1000 way; 0x2000 still hits; the re-fetch of 0x1000 misses.
- rob_clear mid-refill:
  - Stimulus: assert rob_clear after the 2nd mem_ready of a refill.
  - Required: remaining 2 words are still fetched and the line becomes valid; inst_ready stays 0; a later fetch of that line hits with no mem_valid.
- Stall and reset:
  - Stimulus: hold rdy_in = 0 for 5 cycles during REFILL.
  - Required: mem_addr and word_cnt unchanged, then resume.
  - Stimulus: assert rst_in mid-refill.
  - Required: next cycle mem_valid = 0, counters 0, and a subsequent fetch of a previously filled line misses.

Source files
------------

// File: rtl/icache_set_assoc.sv
// rtl/icache_set_assoc.sv - set-associative instruction cache with halfword-window fetch and line refill FSM
//
// Purpose: caches instruction lines for the fetch unit. Each fetch returns the
// little-endian 32-bit window starting at a halfword-aligned address. That
// window may straddle two words or two lines. Misses are refilled one word per
// memory handshake.
//
// Ports:
//   clk_in      system clock
//   rst_in      synchronous active-high reset
//   rdy_in      global ready; all state frozen while low
//   inst_valid  fetch request, held with inst_addr until inst_ready or rob_clear
//   inst_addr   fetch address (bit 0 is always 0)
//   inst_ready  registered: inst_res holds the window for inst_addr
//   inst_res    32-bit window {mem[a+3..a]}
//   mem_valid   refill word request
//   mem_addr    word-aligned refill address
//   mem_result  returned refill word, valid with mem_ready
//   mem_ready   one-cycle completion pulse for mem_addr
//   rob_clear   squashes the pending fetch response
//   hit_cnt     number of inst_ready responses
//   miss_cnt    number of line refills started
module icache_set_assoc #(
    parameter int SET_BIT       = 4,
    parameter int WAY_NUM       = 2,
    parameter int LINE_WORD_BIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        inst_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_res,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_result,
    input  logic        mem_ready,
    input  logic        rob_clear,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int SETS   = 1 << SET_BIT;
    localparam int WORDS  = 1 << LINE_WORD_BIT;
    localparam int LINE_W = 30 - LINE_WORD_BIT;
    localparam int TAG_W  = LINE_W - SET_BIT;
    localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam logic [LINE_WORD_BIT-1:0] LAST_WORD = '1;

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    // storage
    logic [SETS-1:0][WAY_NUM-1:0] r_valid;
    logic [SETS-1:0][WAY_W-1:0]   r_vptr;
    logic [TAG_W-1:0]             r_tag  [SETS][WAY_NUM];
    logic [31:0]                  r_data [SETS][WAY_NUM][WORDS];

    // control / refill context
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LINE_W-1:0]        r_line;
    logic [WAY_W-1:0]         r_victim;
    logic [LINE_WORD_BIT-1:0] r_word_cnt;
    logic                     r_inst_ready;
    logic [31:0]              r_inst_res;
    logic [31:0]              r_hit_cnt;
    logic [31:0]              r_miss_cnt;

    // lookup of word A and word A+1
    logic [29:0]              w_wa;
    logic [29:0]              w_wb;
    logic [SET_BIT-1:0]       w_set_a;
    logic [SET_BIT-1:0]       w_set_b;
    logic [TAG_W-1:0]         w_tag_a;
    logic [TAG_W-1:0]         w_tag_b;
    logic [LINE_WORD_BIT-1:0] w_off_a;
    logic [LINE_WORD_BIT-1:0] w_off_b;
    logic                     w_hit_a;
    logic                     w_hit_b;
    logic [31:0]              w_word_a;
    logic [31:0]              w_word_b;
    logic                     w_all_hit;
    logic [31:0]              w_window;
    logic [LINE_W-1:0]        w_miss_line;
    logic [SET_BIT-1:0]       w_miss_set;
    logic [WAY_W-1:0]         w_victim;
    logic                     w_victim_found;
    logic [SET_BIT-1:0]       w_fill_set;
    logic                     w_start_miss;
    logic                     w_fill_word;
    logic                     w_fill_last;
    logic                     w_unused;

    assign w_unused = inst_addr[0];

    assign w_wa    = inst_addr[31:2];
    assign w_wb    = w_wa + 30'd1;
    assign w_set_a = w_wa[SET_BIT+LINE_WORD_BIT-1:LINE_WORD_BIT];
    assign w_set_b = w_wb[SET_BIT+LINE_WORD_BIT-1:LINE_WORD_BIT];
    assign w_tag_a = w_wa[29:SET_BIT+LINE_WORD_BIT];
    assign w_tag_b = w_wb[29:SET_BIT+LINE_WORD_BIT];
    assign w_off_a = w_wa[LINE_WORD_BIT-1:0];
    assign w_off_b = w_wb[LINE_WORD_BIT-1:0];

    always_comb begin
        w_hit_a  = 1'b0;
        w_hit_b  = 1'b0;
        w_word_a = '0;
        w_word_b = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (r_valid[w_set_a][w] && r_tag[w_set_a][w] == w_tag_a) begin
                w_hit_a  = 1'b1;
                w_word_a = r_data[w_set_a][w][w_off_a];
            end
            if (r_valid[w_set_b][w] && r_tag[w_set_b][w] == w_tag_b) begin
                w_hit_b  = 1'b1;
                w_word_b = r_data[w_set_b][w][w_off_b];
            end
        end
    end

    // Word A+1 is only needed when the window starts on the upper halfword.
    assign w_all_hit = w_hit_a && (!inst_addr[1] || w_hit_b);
    assign w_window  = inst_addr[1] ? {w_word_b[15:0], w_word_a[31:16]} : w_word_a;

    // The line of A is refilled first; line A+1 is picked up on re-evaluation.
    assign w_miss_line = !w_hit_a ? w_wa[29:LINE_WORD_BIT] : w_wb[29:LINE_WORD_BIT];
    assign w_miss_set  = w_miss_line[SET_BIT-1:0];

    // Lowest invalid way wins; otherwise fall back to the round-robin pointer.
    always_comb begin
        w_victim       = r_vptr[w_miss_set];
        w_victim_found = 1'b0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (!w_victim_found && !r_valid[w_miss_set][w]) begin
                w_victim       = WAY_W'(w);
                w_victim_found = 1'b1;
            end
        end
    end

    assign w_fill_set   = r_line[SET_BIT-1:0];
    assign w_start_miss = rdy_in && (r_state == S_IDLE) && inst_valid && !rob_clear && !w_all_hit;
    assign w_fill_word  = rdy_in && (r_state == S_REFILL) && mem_ready;
    assign w_fill_last  = w_fill_word && (r_word_cnt == LAST_WORD);

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start_miss) w_state_nxt = S_REFILL;
            S_REFILL: if (w_fill_last)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        if (r_state == S_REFILL) begin
            mem_valid = 1'b1;
            mem_addr  = {r_line, r_word_cnt, 2'b00};
        end
    end

    // Control, valid bits, replacement pointers and counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid      <= '0;
            r_vptr       <= '0;
            r_line       <= '0;
            r_victim     <= '0;
            r_word_cnt   <= '0;
            r_inst_ready <= 1'b0;
            r_inst_res   <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (rob_clear) begin
                r_inst_ready <= 1'b0;
                r_inst_res   <= '0;
            end else if (rdy_in) begin
                r_inst_ready <= 1'b0;
                if (r_state == S_IDLE && inst_valid && w_all_hit) begin
                    r_inst_ready <= 1'b1;
                    r_inst_res   <= w_window;
                    r_hit_cnt    <= r_hit_cnt + 32'd1;
                end
            end

            if (w_start_miss) begin
                r_line     <= w_miss_line;
                r_victim   <= w_victim;
                r_word_cnt <= '0;
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end

            // A refill always runs to completion, even across rob_clear.
            if (w_fill_word) begin
                r_word_cnt <= r_word_cnt + LINE_WORD_BIT'(1);
            end
            if (w_fill_last) begin
                r_valid[w_fill_set][r_victim] <= 1'b1;
                if (&r_valid[w_fill_set]) begin
                    r_vptr[w_fill_set] <= (r_vptr[w_fill_set] == WAY_W'(WAY_NUM - 1))
                                          ? '0 : r_vptr[w_fill_set] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked by r_valid.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_fill_word) begin
            r_data[w_fill_set][r_victim][r_word_cnt] <= mem_result;
            if (r_word_cnt == LAST_WORD) begin
                r_tag[w_fill_set][r_victim] <= r_line[LINE_W-1:SET_BIT];
            end
        end
    end

    assign inst_ready = r_inst_ready;
    assign inst_res   = r_inst_res;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_icache_set_assoc.sv
// tb/tb_icache_set_assoc.sv - directed self-checking bench for icache_set_assoc
module tb_icache_set_assoc;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_res;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_result;
    logic        mem_ready;
    logic        rob_clear;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem_log [$];
    int          mv_cycles;
    int          rdy_seen;

    icache_set_assoc #(.SET_BIT(4), .WAY_NUM(2), .LINE_WORD_BIT(2)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .inst_valid (inst_valid),
        .inst_addr  (inst_addr),
        .inst_ready (inst_ready),
        .inst_res   (inst_res),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_result (mem_result),
        .mem_ready  (mem_ready),
        .rob_clear  (rob_clear),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h1000: mem_word = 32'h1111_1111;
            32'h1004: mem_word = 32'h2222_2222;
            32'h1008: mem_word = 32'h3333_3333;
            32'h100C: mem_word = 32'h4444_4444;
            default:  mem_word = {~a[15:0], a[15:0]};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: answers each word request two cycles after it is seen.
    initial begin
        int cnt;
        cnt        = 0;
        mem_ready  = 1'b0;
        mem_result = '0;
        mv_cycles  = 0;
        rdy_seen   = 0;
        forever begin
            @(negedge clk_in);
            mem_ready = 1'b0;
            if (mem_valid) mv_cycles++;
            if (inst_ready) rdy_seen++;
            if (mem_valid && rdy_in && !rst_in) begin
                if (cnt == 1) begin
                    mem_ready  = 1'b1;
                    mem_result = mem_word(mem_addr);
                    mem_log.push_back(mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] res, output int cyc);
        bit done;
        done       = 1'b0;
        res        = '0;
        cyc        = 0;
        inst_addr  = a;
        inst_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (inst_ready) begin
                res  = inst_res;
                done = 1'b1;
            end
        end
        if (!done) check_eq("fetch_timeout", {31'b0, inst_ready}, 32'd1);
        inst_valid = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 400 && mem_log.size() < n; i++) begin
            @(posedge clk_in);
            #1;
        end
        check_eq("wait_log", mem_log.size(), n);
    endtask

    task automatic check_reqs(input string tag, input logic [31:0] base);
        check_eq({tag, "_nreq"}, mem_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < mem_log.size()) check_eq({tag, "_req"}, mem_log[i], base + 32'(4 * i));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [31:0] res;
        int          cyc;

        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        inst_valid = 1'b0;
        inst_addr  = '0;
        rob_clear  = 1'b0;
        idle(2);
        check_eq("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
        check_eq("rst_inst_res", inst_res, 32'd0);
        check_eq("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_hit_cnt", hit_cnt, 32'd0);
        check_eq("rst_miss_cnt", miss_cnt, 32'd0);
        rst_in = 1'b0;
        idle(1);

        // cold aligned miss
        mem_log.delete();
        do_fetch(32'h1000, res, cyc);
        check_reqs("cold", 32'h1000);
        check_eq("cold_res", res, 32'h1111_1111);
        check_eq("cold_miss_cnt", miss_cnt, 32'd1);
        check_eq("cold_hit_cnt", hit_cnt, 32'd1);
        idle(1);

        // halfword window inside a line
        mem_log.delete();
        mv_cycles = 0;
        do_fetch(32'h1002, res, cyc);
        check_eq("half_res", res, 32'h2222_1111);
        check_eq("half_latency", cyc, 1);
        check_eq("half_mem_valid", mv_cycles, 0);
        idle(1);

        // line-straddling fetch refills the next line
        mem_log.delete();
        do_fetch(32'h100E, res, cyc);
        check_reqs("strad", 32'h1010);
        check_eq("strad_res", res, 32'h1010_4444);
        check_eq("strad_miss_cnt", miss_cnt, 32'd2);
        check_eq("strad_hit_cnt", hit_cnt, 32'd3);
        idle(1);

        // associativity and round-robin replacement in set 0
        mem_log.delete();
        do_fetch(32'h2000, res, cyc);
        check_reqs("w2000", 32'h2000);
        check_eq("w2000_res", res, 32'hDFFF_2000);
        idle(1);
        mem_log.delete();
        do_fetch(32'h3000, res, cyc);
        check_reqs("w3000", 32'h3000);
        check_eq("w3000_miss_cnt", miss_cnt, 32'd4);
        idle(1);
        mem_log.delete();
        mv_cycles = 0;
        do_fetch(32'h2000, res, cyc);
        check_eq("w2000_hit_latency", cyc, 1);
        check_eq("w2000_hit_mem_valid", mv_cycles, 0);
        check_eq("w2000_hit_res", res, 32'hDFFF_2000);
        idle(1);
        mem_log.delete();
        do_fetch(32'h1000, res, cyc);
        check_reqs("evicted", 32'h1000);
        check_eq("evicted_res", res, 32'h1111_1111);
        check_eq("evicted_miss_cnt", miss_cnt, 32'd5);
        check_eq("evicted_hit_cnt", hit_cnt, 32'd7);
        idle(1);

        // rob_clear after the second word of a refill
        mem_log.delete();
        inst_addr  = 32'h4000;
        inst_valid = 1'b1;
        wait_log(2);
        rob_clear  = 1'b1;
        inst_valid = 1'b0;
        rdy_seen   = 0;
        idle(1);
        rob_clear = 1'b0;
        check_eq("rob_inst_ready", {31'b0, inst_ready}, 32'd0);
        check_eq("rob_inst_res", inst_res, 32'd0);
        for (int i = 0; i < 100 && mem_valid; i++) idle(1);
        idle(2);
        check_reqs("rob", 32'h4000);
        check_eq("rob_no_response", rdy_seen, 0);
        check_eq("rob_miss_cnt", miss_cnt, 32'd6);
        check_eq("rob_hit_cnt", hit_cnt, 32'd7);
        mem_log.delete();
        mv_cycles = 0;
        do_fetch(32'h4000, res, cyc);
        check_eq("rob_refetch_latency", cyc, 1);
        check_eq("rob_refetch_mem_valid", mv_cycles, 0);
        check_eq("rob_refetch_res", res, 32'hBFFF_4000);
        idle(1);

        // stall during refill
        mem_log.delete();
        inst_addr  = 32'h5000;
        inst_valid = 1'b1;
        wait_log(1);
        check_eq("stall_addr_pre", mem_addr, 32'h5004);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check_eq("stall_mem_addr", mem_addr, 32'h5004);
            check_eq("stall_mem_valid", {31'b0, mem_valid}, 32'd1);
        end
        check_eq("stall_nreq", mem_log.size(), 1);
        rdy_in = 1'b1;
        do_fetch(32'h5000, res, cyc);
        check_reqs("stall", 32'h5000);
        check_eq("stall_res", res, 32'hAFFF_5000);
        check_eq("stall_miss_cnt", miss_cnt, 32'd7);
        check_eq("stall_hit_cnt", hit_cnt, 32'd9);
        idle(1);

        // reset in the middle of a refill
        mem_log.delete();
        inst_addr  = 32'h6000;
        inst_valid = 1'b1;
        wait_log(1);
        rst_in     = 1'b1;
        inst_valid = 1'b0;
        idle(1);
        check_eq("mrst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check_eq("mrst_hit_cnt", hit_cnt, 32'd0);
        check_eq("mrst_miss_cnt", miss_cnt, 32'd0);
        check_eq("mrst_inst_ready", {31'b0, inst_ready}, 32'd0);
        rst_in = 1'b0;
        idle(2);
        mem_log.delete();
        do_fetch(32'h5000, res, cyc);
        check_reqs("post_rst", 32'h5000);
        check_eq("post_rst_res", res, 32'hAFFF_5000);
        check_eq("post_rst_miss_cnt", miss_cnt, 32'd1);
        check_eq("post_rst_hit_cnt", hit_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
